exe_multilane: RTL and testbench

Parametrised execute stage for the out-of-order MIPS core, successor to the fixed dual-issue execute stage. Each of `LANES` ALU lanes resolves its operands through a `FWD_SRCS`-deep forwarding network, computes a result, and registers it into the EXE/MEM pipeline register. A dedicated load/store lane computes effective addresses with alignment checking. Each ALU lane also owns HI/LO registers fed by a multi-cycle signed multiplier that stalls issue while busy.

---
 rtl/exe_multilane.sv | 187 ++++++++++++++++++
 tb/tb_exe_multilane.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_multilane.sv
// exe_multilane: N-lane ALU execute stage with forwarding, per-lane HI/LO
// multiplier, and a load/store address lane feeding the EXE/MEM register.
module exe_multilane #(
  parameter int LANES    = 2,
  parameter int FWD_SRCS = 3,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 6,
  parameter int MUL_LAT  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FREEZE,
  input  logic [LANES-1:0]            in_valid,
  input  logic [4*LANES-1:0]          op,
  input  logic [5*LANES-1:0]          shamt,
  input  logic [REG_W*LANES-1:0]      src_a_tag,
  input  logic [REG_W*LANES-1:0]      src_b_tag,
  input  logic [DATA_W*LANES-1:0]     src_a_val,
  input  logic [DATA_W*LANES-1:0]     src_b_val,
  input  logic [DATA_W*LANES-1:0]     imm,
  input  logic [LANES-1:0]            use_imm,
  input  logic [REG_W*LANES-1:0]      dst_tag,
  input  logic [FWD_SRCS-1:0]         fwd_valid,
  input  logic [REG_W*FWD_SRCS-1:0]   fwd_tag,
  input  logic [DATA_W*FWD_SRCS-1:0]  fwd_data,
  input  logic                        ls_valid,
  input  logic                        ls_is_load,
  input  logic [1:0]                  ls_size,
  input  logic [REG_W-1:0]            ls_base_tag,
  input  logic [REG_W-1:0]            ls_data_tag,
  input  logic [DATA_W-1:0]           ls_base_val,
  input  logic [DATA_W-1:0]           ls_data_val,
  input  logic [DATA_W-1:0]           ls_offset,
  input  logic [REG_W-1:0]            ls_dst_tag,
  output logic                        stall_out,
  output logic [LANES-1:0]            res_valid,
  output logic [DATA_W*LANES-1:0]     res_data,
  output logic [REG_W*LANES-1:0]      res_tag,
  output logic                        ls_out_valid,
  output logic                        ls_out_load,
  output logic [DATA_W-1:0]           ls_addr,
  output logic [DATA_W-1:0]           ls_store_data,
  output logic [REG_W-1:0]            ls_out_tag,
  output logic [1:0]                  ls_out_size,
  output logic                        ls_misaligned
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic { IDLE, BUSY } mst_e;

  logic [LANES-1:0] busy;
  assign stall_out = |busy;

  // Walk from the lowest-priority source up so the lowest index wins.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_W-1:0]  t,
    input logic [DATA_W-1:0] v
  );
    fwd = v;
    for (int j = FWD_SRCS - 1; j >= 0; j--)
      if (fwd_valid[j] && t != '0 &&
          fwd_tag[j*REG_W +: REG_W] == t)
        fwd = fwd_data[j*DATA_W +: DATA_W];
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0]          opc;
    logic [4:0]          sh;
    logic [DATA_W-1:0]   a, b, alu_d;
    logic                wr_d, acc, is_mul;
    logic [2*DATA_W-1:0] prod, prod_q;
    mst_e                st_q;
    logic [CW-1:0]       cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q, data_q;
    logic [REG_W-1:0]    tag_q;
    logic                vld_q;

    always_comb begin
      opc = op[4*l +: 4];
      sh  = shamt[5*l +: 5];
      a   = fwd(src_a_tag[REG_W*l +: REG_W],
                src_a_val[DATA_W*l +: DATA_W]);
      b   = use_imm[l] ? imm[DATA_W*l +: DATA_W]
                       : fwd(src_b_tag[REG_W*l +: REG_W],
                             src_b_val[DATA_W*l +: DATA_W]);
      acc    = in_valid[l] & ~FREEZE & ~stall_out;
      is_mul = opc == 4'd9;
      // Sign-extend both to full width; low 2*DATA_W bits are exact.
      prod = {{DATA_W{a[DATA_W-1]}}, a} *
             {{DATA_W{b[DATA_W-1]}}, b};
      wr_d  = 1'b1;
      alu_d = '0;
      case (opc)
        4'd0:  alu_d = a + b;
        4'd1:  alu_d = a - b;
        4'd2:  alu_d = a & b;
        4'd3:  alu_d = a | b;
        4'd4:  alu_d = a ^ b;
        4'd5:  alu_d = {{(DATA_W-1){1'b0}},
                        $signed(a) < $signed(b)};
        4'd6:  alu_d = b << sh;
        4'd7:  alu_d = b >> sh;
        4'd8:  alu_d = $signed(b) >>> sh;
        4'd10: alu_d = hi_q;
        4'd11: alu_d = lo_q;
        default: wr_d = 1'b0;
      endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        prod_q <= '0;
        hi_q   <= '0;
        lo_q   <= '0;
        vld_q  <= 1'b0;
        data_q <= '0;
        tag_q  <= '0;
      end else if (!FREEZE) begin
        vld_q  <= acc & wr_d;
        data_q <= alu_d;
        tag_q  <= dst_tag[REG_W*l +: REG_W];
        case (st_q)
          IDLE: if (acc && is_mul) begin
            if (MUL_LAT > 1) begin
              st_q   <= BUSY;
              cnt_q  <= CW'(MUL_LAT - 1);
              prod_q <= prod;
            end else begin
              hi_q <= prod[2*DATA_W-1:DATA_W];
              lo_q <= prod[DATA_W-1:0];
            end
          end
          BUSY: if (cnt_q == CW'(1)) begin
            st_q <= IDLE;
            hi_q <= prod_q[2*DATA_W-1:DATA_W];
            lo_q <= prod_q[DATA_W-1:0];
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
          default: st_q <= IDLE;
        endcase
      end
    end

    assign busy[l]                    = st_q == BUSY;
    assign res_valid[l]               = vld_q;
    assign res_data[DATA_W*l +: DATA_W] = data_q;
    assign res_tag[REG_W*l +: REG_W]  = tag_q;
  end

  logic [DATA_W-1:0] ls_addr_d;
  logic              ls_mis_d, ls_acc;

  always_comb begin
    ls_acc    = ls_valid & ~FREEZE & ~stall_out;
    ls_addr_d = fwd(ls_base_tag, ls_base_val) + ls_offset;
    unique case (1'b1)
      ls_size == 2'd0: ls_mis_d = 1'b0;
      ls_size == 2'd1: ls_mis_d = ls_addr_d[0];
      default:         ls_mis_d = |ls_addr_d[1:0];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ls_out_valid  <= 1'b0;
      ls_out_load   <= 1'b0;
      ls_addr       <= '0;
      ls_store_data <= '0;
      ls_out_tag    <= '0;
      ls_out_size   <= '0;
      ls_misaligned <= 1'b0;
    end else if (!FREEZE) begin
      ls_out_valid  <= ls_acc;
      ls_out_load   <= ls_is_load;
      ls_addr       <= ls_addr_d;
      ls_store_data <= fwd(ls_data_tag, ls_data_val);
      ls_out_tag    <= ls_dst_tag;
      ls_out_size   <= ls_size;
      ls_misaligned <= ls_mis_d;
    end
  end

endmodule

// File: tb/tb_exe_multilane.sv
// tb_exe_multilane: directed vectors with hand-computed results for
// forwarding, ALU ops, LS addressing, multiply stall, freeze and reset.
module tb_exe_multilane;
  localparam int L = 2, F = 3, W = 32, R = 6;

  logic CLK = 1'b0, RESET = 1'b1, FREEZE = 1'b0;
  logic [L-1:0]   in_valid, use_imm, res_valid;
  logic [4*L-1:0] op;
  logic [5*L-1:0] shamt;
  logic [R*L-1:0] src_a_tag, src_b_tag, dst_tag, res_tag;
  logic [W*L-1:0] src_a_val, src_b_val, imm, res_data;
  logic [F-1:0]   fwd_valid;
  logic [R*F-1:0] fwd_tag;
  logic [W*F-1:0] fwd_data;
  logic ls_valid, ls_is_load, stall_out, ls_out_valid, ls_out_load;
  logic ls_misaligned;
  logic [1:0] ls_size, ls_out_size;
  logic [R-1:0] ls_base_tag, ls_data_tag, ls_dst_tag, ls_out_tag;
  logic [W-1:0] ls_base_val, ls_data_val, ls_offset;
  logic [W-1:0] ls_addr, ls_store_data;

  int errors = 0, checks = 0, n;

  exe_multilane dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .in_valid(in_valid), .op(op), .shamt(shamt),
    .src_a_tag(src_a_tag), .src_b_tag(src_b_tag),
    .src_a_val(src_a_val), .src_b_val(src_b_val),
    .imm(imm), .use_imm(use_imm), .dst_tag(dst_tag),
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
    .ls_valid(ls_valid), .ls_is_load(ls_is_load), .ls_size(ls_size),
    .ls_base_tag(ls_base_tag), .ls_data_tag(ls_data_tag),
    .ls_base_val(ls_base_val), .ls_data_val(ls_data_val),
    .ls_offset(ls_offset), .ls_dst_tag(ls_dst_tag),
    .stall_out(stall_out), .res_valid(res_valid),
    .res_data(res_data), .res_tag(res_tag),
    .ls_out_valid(ls_out_valid), .ls_out_load(ls_out_load),
    .ls_addr(ls_addr), .ls_store_data(ls_store_data),
    .ls_out_tag(ls_out_tag), .ls_out_size(ls_out_size),
    .ls_misaligned(ls_misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic clr;
    in_valid = '0; op = '0; shamt = '0; use_imm = '0;
    src_a_tag = '0; src_b_tag = '0; dst_tag = '0;
    src_a_val = '0; src_b_val = '0; imm = '0;
    fwd_valid = '0; fwd_tag = '0; fwd_data = '0;
    ls_valid = 0; ls_is_load = 0; ls_size = '0;
    ls_base_tag = '0; ls_data_tag = '0; ls_dst_tag = '0;
    ls_base_val = '0; ls_data_val = '0; ls_offset = '0;
  endtask

  task automatic lane(input int l, input logic [3:0] o,
                      input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [4:0] sh, input logic [R-1:0] d);
    in_valid[l] = 1'b1;
    op[4*l +: 4] = o;
    src_a_tag[R*l +: R] = R'(1);
    src_b_tag[R*l +: R] = R'(2);
    src_a_val[W*l +: W] = va;
    src_b_val[W*l +: W] = vb;
    shamt[5*l +: 5] = sh;
    use_imm[l] = 1'b0;
    dst_tag[R*l +: R] = d;
  endtask

  logic [3:0]   t_op [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5,
                              4'd6, 4'd7, 4'd8, 4'd0, 4'd13};
  logic [W-1:0] t_a  [11] = '{5, 'hF0F0, 'hF000, 'hFF, 'hFFFFFFFF, 1,
                              0, 0, 0, 'hFFFFFFFF, 1};
  logic [W-1:0] t_b  [11] = '{7, 'h0FF0, 'h000F, 'h0F, 1, 'hFFFFFFFF,
                              1, 'h80000000, 'h80000000, 2, 1};
  logic [W-1:0] t_e  [11] = '{'hFFFFFFFE, 'h00F0, 'hF00F, 'hF0, 1, 0,
                              'h10, 'h08000000, 'hF8000000, 1, 0};

  initial begin
    clr();
    step(); step();
    chk("rst_stall", stall_out, 0);
    chk("rst_rvalid", res_valid, 0);
    chk("rst_rdata", res_data, 0);
    chk("rst_ls", {ls_out_valid, ls_addr, ls_misaligned}, 0);
    RESET = 0;

    // Forwarding priority: fwd0 beats fwd2, both beat regfile.
    lane(0, 4'd0, 1, 0, 0, 6'd7);
    src_a_tag[R-1:0] = 6'd5;
    use_imm[0] = 1'b1; imm[W-1:0] = 3;
    fwd_valid = 3'b101;
    fwd_tag = {6'd5, 6'd0, 6'd5};
    fwd_data = {32'h20, 32'h0, 32'h10};
    step();
    chk("fwd_prio", res_data[W-1:0], 'h13);
    chk("fwd_tag", res_tag[R-1:0], 7);
    chk("fwd_vld", res_valid, 2'b01);

    // Tag 0 must never be forwarded.
    clr();
    lane(0, 4'd0, 0, 0, 0, 6'd8);
    src_a_tag[R-1:0] = 6'd0;
    use_imm[0] = 1'b1;
    fwd_valid = 3'b001; fwd_tag = '0; fwd_data[W-1:0] = 'hFF;
    step();
    chk("tag0", res_data[W-1:0], 0);

    for (int i = 0; i < 11; i++) begin
      clr();
      lane(1, t_op[i], t_a[i], t_b[i], 5'd4, 6'd9);
      step();
      chk($sformatf("alu%0d_d", i), res_data[2*W-1:W], t_e[i]);
      chk($sformatf("alu%0d_v", i), res_valid,
          {t_op[i] != 4'd13, 1'b0});
    end

    // LS lane addressing and alignment.
    clr();
    ls_valid = 1; ls_is_load = 1; ls_size = 2; ls_dst_tag = 6'd12;
    ls_base_tag = 6'd4; ls_base_val = 'h1000; ls_offset = 6;
    step();
    chk("ls_addr", ls_addr, 'h1006);
    chk("ls_mis_w", ls_misaligned, 1);
    chk("ls_meta", {ls_out_valid, ls_out_load, ls_out_tag, ls_out_size},
        {1'b1, 1'b1, 6'd12, 2'd2});
    ls_size = 1;
    step();
    chk("ls_mis_h", ls_misaligned, 0);
    ls_is_load = 0; ls_size = 3; ls_offset = 2;
    ls_data_tag = 6'd9; ls_data_val = 'h55;
    fwd_valid = 3'b011;
    fwd_tag = {6'd0, 6'd4, 6'd9};
    fwd_data = {32'h0, 32'h2000, 32'hAB};
    step();
    chk("ls_fwd_addr", ls_addr, 'h2002);
    chk("ls_mis_s3", ls_misaligned, 1);
    chk("ls_sdata", ls_store_data, 'hAB);
    chk("ls_store", ls_out_load, 0);

    // MULT -3x5: three stall cycles, bubbles while stalled.
    clr();
    lane(0, 4'd9, 'hFFFFFFFD, 5, 0, 6'd0);
    lane(1, 4'd0, 1, 1, 0, 6'd3);
    ls_valid = 1;
    step();
    in_valid[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall_out) break;
      n++;
      if (i >= 1)
        chk("stall_bubble", {res_valid, ls_out_valid}, 0);
      step();
    end
    chk("mul_stall_cyc", n, 3);
    clr();
    lane(0, 4'd11, 0, 0, 0, 6'd4);
    step();
    chk("mflo", res_data[W-1:0], 'hFFFFFFF1);
    lane(0, 4'd10, 0, 0, 0, 6'd4);
    step();
    chk("mfhi", res_data[W-1:0], 'hFFFFFFFF);

    // FREEZE for 2 cycles stretches the stall by 2 and holds outputs.
    clr();
    lane(0, 4'd0, 'h100, 0, 0, 6'd3);
    use_imm[0] = 1'b1; imm[W-1:0] = 'h23;
    lane(1, 4'd9, 7, 6, 0, 6'd0);
    step();
    in_valid = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stall_out) break;
      n++;
      FREEZE = i < 2;
      if (i == 2) begin
        chk("frz_vld", res_valid, 2'b01);
        chk("frz_data", res_data[W-1:0], 'h123);
      end
      step();
    end
    FREEZE = 0;
    chk("frz_stall_cyc", n, 5);
    clr();
    lane(1, 4'd11, 0, 0, 0, 6'd5);
    step();
    chk("mflo1", res_data[2*W-1:W], 42);
    lane(1, 4'd10, 0, 0, 0, 6'd5);
    step();
    chk("mfhi1", res_data[2*W-1:W], 0);

    // Asynchronous reset while lane0 multiply is busy.
    clr();
    lane(0, 4'd9, 7, 6, 0, 6'd0);
    lane(1, 4'd0, 1, 1, 0, 6'd3);
    ls_valid = 1; ls_base_val = 'h40;
    step();
    clr();
    chk("pre_rst", {stall_out, res_valid, ls_out_valid}, 4'b1101);
    RESET = 1;
    #1;
    chk("arst_stall", stall_out, 0);
    chk("arst_res", {res_valid, res_data, res_tag}, 0);
    chk("arst_ls", {ls_out_valid, ls_addr}, 0);
    #1 RESET = 0;
    lane(0, 4'd10, 0, 0, 0, 6'd4);
    step();
    chk("rst_mfhi", res_data[W-1:0], 0);
    chk("rst_mfhi_v", res_valid, 2'b01);
    lane(0, 4'd11, 0, 0, 0, 6'd4);
    step();
    chk("rst_mflo", res_data[W-1:0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
